// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // Integer clocks-per-bit for a given system clock and line rate.
    function automatic int unsigned calc_div(input int unsigned clock, input int unsigned baud);
        return clock / baud;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period tick generator: counts 0..DIV-1 while enabled and flags the last count.
module uart_tx_baud_gen #(
    parameter int unsigned DIV = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // Clear restarts the bit period on acceptance; otherwise wrap at DIV-1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    assign tick_o = en_i && w_last;

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits.
// Optional parity bit and parity_odd_i port are enabled with `define UART_TX_PARITY_EN.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK     = 100000000,
    parameter int unsigned BAUD_RATE = 20000000,
    parameter int unsigned DIV       = calc_div(CLOCK, BAUD_RATE),
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
`ifdef UART_TX_PARITY_EN
    input  logic                 parity_odd_i,
`endif
    output logic                 tx_ready_o,
    output logic                 tx_o,
    output logic                 tx_busy_o,
    output logic                 tx_done_o
);

    localparam int unsigned IW = $clog2(DATA_BITS);

    // Reject illegal configurations at elaboration.
    generate
        if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_cfg_chk
            $error("uart_tx: illegal configuration (DIV>=2, DATA_BITS 5..9, STOP_BITS 1..2)");
        end
    endgenerate

    tx_state_e          r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [IW-1:0]      r_idx;
    logic               r_stop_cnt;
    logic               r_tx;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
`ifdef UART_TX_PARITY_EN
    logic               r_par;
`endif

    logic w_accept;
    logic w_tick;
    logic w_en;

    assign w_accept = tx_valid_i && r_ready;
    assign w_en     = (r_state != TX_IDLE);

    uart_tx_baud_gen #(
        .DIV(DIV)
    ) u_baud_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (w_en),
        .clear_i(w_accept),
        .tick_o (w_tick)
    );

    // Frame sequencer; tx_o is loaded with the level of the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= TX_IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= IDLE_LEVEL;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    if (w_accept) begin
                        r_shift <= tx_data_i;
`ifdef UART_TX_PARITY_EN
                        r_par   <= ^tx_data_i;
`endif
                        r_tx    <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        r_idx   <= r_idx + IW'(1);
                        if (r_idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_par ^ parity_odd_i;
                            r_state <= TX_PARITY;
`else
                            r_tx       <= IDLE_LEVEL;
                            r_stop_cnt <= 1'b0;
                            r_state    <= TX_STOP;
`endif
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    if (w_tick) begin
                        r_tx       <= IDLE_LEVEL;
                        r_stop_cnt <= 1'b0;
                        r_state    <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (w_tick) begin
                        if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= TX_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= IDLE_LEVEL;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_o       = r_tx;
    assign tx_ready_o = r_ready;
    assign tx_busy_o  = r_busy;
    assign tx_done_o  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx against a bit-level frame model.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int unsigned CLOCK     = 100000000;
    localparam int unsigned BAUD      = 20000000;
    localparam int unsigned DIV       = CLOCK / BAUD;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR_BITS  = 1;
`else
    localparam int unsigned PAR_BITS  = 0;
`endif
    localparam int unsigned FRAME_CLKS = (1 + DATA_BITS + PAR_BITS + STOP_BITS) * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       parity_odd = 1'b0;
    logic       tx_ready_o, tx_o, tx_busy_o, tx_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLOCK    (CLOCK),
        .BAUD_RATE(BAUD),
        .DATA_BITS(DATA_BITS),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
`ifdef UART_TX_PARITY_EN
        .parity_odd_i(parity_odd),
`endif
        .tx_ready_o  (tx_ready_o),
        .tx_o        (tx_o),
        .tx_busy_o   (tx_busy_o),
        .tx_done_o   (tx_done_o)
    );

    // Expected line level k clocks after acceptance (k=0 is the first start-bit clock).
    function automatic logic exp_line(input logic [7:0] d, input logic odd, input int unsigned k);
        int unsigned b;
        b = k / DIV;
        if (b == 0) return 1'b0;
        if (b <= DATA_BITS) return d[b-1];
        if (PAR_BITS == 1 && b == DATA_BITS + 1)
            return logic'(($countones(d) + int'(odd)) % 2);
        return 1'b1;
    endfunction

    // Wait (bounded) for ready, then present one byte for exactly one handshake.
    task automatic accept(input logic [7:0] d, input logic odd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: tx_ready_o=%b, required 1", tx_ready_o);
            return;
        end
        tx_data    = d;
        tx_valid   = 1'b1;
        parity_odd = odd;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Check every clock of the frame plus the completion cycle; optionally pulse valid mid-frame.
    task automatic check_frame(input logic [7:0] d, input logic odd, input int inject_at);
        logic e;
        for (int k = 0; k < int'(FRAME_CLKS); k++) begin
            @(negedge clk);
            e = exp_line(d, odd, k);
            n_tests++;
            if (tx_o !== e || tx_busy_o !== 1'b1 || tx_ready_o !== 1'b0 || tx_done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL frame d=%h clk+%0d: tx_o=%b busy=%b ready=%b done=%b, required tx_o=%b busy=1 ready=0 done=0",
                         d, k + 1, tx_o, tx_busy_o, tx_ready_o, tx_done_o, e);
            end
            if (inject_at >= 0 && k == inject_at) begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
            end else if (inject_at >= 0 && k == inject_at + 1) begin
                tx_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_tests++;
        if (tx_done_o !== 1'b1 || tx_ready_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_o !== 1'b1) begin
            n_fail++;
            $display("FAIL done d=%h: done=%b ready=%b busy=%b tx_o=%b, required done=1 ready=1 busy=0 tx_o=1",
                     d, tx_done_o, tx_ready_o, tx_busy_o, tx_o);
        end
    endtask

    // Line must sit idle for n clocks with no completion pulse.
    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_tests++;
            if (tx_o !== 1'b1 || tx_ready_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s idle+%0d: tx_o=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                         name, i, tx_o, tx_ready_o, tx_busy_o, tx_done_o);
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset_release", 2);
        accept(8'h00, 1'b0, ok);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (tx_o !== 1'b1 || tx_ready_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: tx_o=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                     tx_o, tx_ready_o, tx_busy_o, tx_done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("after_async_reset", 3);
    endtask

    task automatic test_single();
        bit ok;
        accept(8'hA5, 1'b0, ok);
        if (ok) begin
            check_frame(8'hA5, 1'b0, -1);
            check_idle("single_done_pulse", 1);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL b2b_ready_timeout: tx_ready_o=%b, required 1", tx_ready_o);
            return;
        end
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'hFF;
        check_frame(8'h00, parity_odd, -1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_frame(8'hFF, parity_odd, -1);
        check_idle("b2b_tail", 2);
    endtask

    task automatic test_valid_while_busy();
        bit ok;
        logic [7:0] d;
        d = 8'($urandom);
        accept(d, 1'b0, ok);
        if (ok) begin
            check_frame(d, 1'b0, 9);
            check_idle("busy_no_extra_frame", 2 * int'(FRAME_CLKS));
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        accept(8'($urandom), 1'b0, ok);
        if (!ok) return;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (tx_o !== 1'b1 || tx_busy_o !== 1'b0 || tx_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_reset: tx_o=%b busy=%b ready=%b, required 1 0 1", tx_o, tx_busy_o, tx_ready_o);
        end
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (tx_o !== 1'b1 || tx_done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL in_reset: tx_o=%b done=%b, required 1 0", tx_o, tx_done_o);
            end
        end
        rst_n = 1'b1;
        check_idle("after_mid_reset", int'(FRAME_CLKS) + 5);
        accept(8'h81, 1'b0, ok);
        if (ok) check_frame(8'h81, 1'b0, -1);
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] d;
        logic odd;
        for (int i = 0; i < 8; i++) begin
            d   = 8'($urandom);
            odd = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            accept(d, odd, ok);
            if (ok) check_frame(d, odd, -1);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit ok;
        accept(8'hA5, 1'b0, ok);
        if (ok) check_frame(8'hA5, 1'b0, -1);
        accept(8'hA5, 1'b1, ok);
        if (ok) check_frame(8'hA5, 1'b1, -1);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_valid_while_busy();
        test_reset_mid_frame();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
